// File: rtl/dual_bit_serializer.sv
// Serializes a word pair (A on x, B on y) MSB-first after a one-cycle frame_rst pulse; accept-to-MSB is 2 edges.
// Backpressure: load_ready only in IDLE or on the last bit, so back-to-back frames run WIDTH+1 cycles each.
module dual_bit_serializer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_valid_i,
    input  logic [WIDTH-1:0] word_a_i,
    input  logic [WIDTH-1:0] word_b_i,
    input  logic             abort_i,
    output logic             load_ready_o,
    output logic             x_o,
    output logic             y_o,
    output logic             bit_valid_o,
    output logic             first_bit_o,
    output logic             last_bit_o,
    output logic             frame_rst_o,
    output logic [CNT_W-1:0] frames_sent_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SYNC, SHIFT} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [CNT_W-1:0]  frames_q, frames_d;
    logic              accept;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            frames_q <= frames_d;
        end
    end

    // load_ready is the only output allowed to see inputs (rst/abort gate it).
    always_comb begin
        load_ready_o = !rst_i && !abort_i &&
                       ((state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == '0)));
        accept       = load_valid_i && load_ready_o;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        frames_d = frames_q;
        if (abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            a_d     = '0;
            b_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = SYNC;
                        a_d     = word_a_i;
                        b_d     = word_b_i;
                    end
                end
                SYNC: begin
                    state_d = SHIFT;
                    cnt_d   = CNT_MAX;
                end
                SHIFT: begin
                    a_d   = a_q << 1;
                    b_d   = b_q << 1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        frames_d = frames_q + 1'b1;
                        cnt_d    = '0;
                        if (accept) begin
                            state_d = SYNC;
                            a_d     = word_a_i;
                            b_d     = word_b_i;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Shift registers move left, so the current bit is always the top bit.
    always_comb begin
        x_o         = 1'b0;
        y_o         = 1'b0;
        bit_valid_o = 1'b0;
        first_bit_o = 1'b0;
        last_bit_o  = 1'b0;
        frame_rst_o = 1'b0;
        case (state_q)
            SYNC:  frame_rst_o = 1'b1;
            SHIFT: begin
                x_o         = a_q[WIDTH-1];
                y_o         = b_q[WIDTH-1];
                bit_valid_o = 1'b1;
                first_bit_o = (cnt_q == CNT_MAX);
                last_bit_o  = (cnt_q == '0);
            end
            default: ;
        endcase
    end

    assign frames_sent_o = frames_q;

endmodule

// File: tb/tb_dual_bit_serializer.sv
// Directed bench: a 16-bit instance for framing/abort/reset and a 2-bit instance with a 2-bit frame counter.
module tb_dual_bit_serializer;

    logic        clk;
    logic        rst;
    logic        abort;
    logic        lv;
    logic [15:0] wa, wb;
    logic        ready, x, y, bv, first, last, frst;
    logic [7:0]  frames;

    logic        lv2;
    logic [1:0]  wa2, wb2;
    logic        ready2, x2, y2, bv2, first2, last2, frst2;
    logic [1:0]  frames2;

    logic [5:0]  o1, o2;
    int          n_vec = 0;
    int          n_err = 0;
    int          busy  = 0;
    int          wrap_exp [5] = '{1, 2, 3, 0, 1};

    assign o1 = {x, y, bv, first, last, frst};
    assign o2 = {x2, y2, bv2, first2, last2, frst2};

    dual_bit_serializer #(.WIDTH(16), .CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .load_valid_i(lv), .word_a_i(wa), .word_b_i(wb),
        .abort_i(abort), .load_ready_o(ready), .x_o(x), .y_o(y), .bit_valid_o(bv),
        .first_bit_o(first), .last_bit_o(last), .frame_rst_o(frst), .frames_sent_o(frames)
    );

    dual_bit_serializer #(.WIDTH(2), .CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .load_valid_i(lv2), .word_a_i(wa2), .word_b_i(wb2),
        .abort_i(1'b0), .load_ready_o(ready2), .x_o(x2), .y_o(y2), .bit_valid_o(bv2),
        .first_bit_o(first2), .last_bit_o(last2), .frame_rst_o(frst2), .frames_sent_o(frames2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (bv || frst) busy++;
    endtask

    // Sixteen SHIFT cycles; expected bits come from the words handed in.
    task automatic shift_check(input logic [15:0] a, input logic [15:0] b);
        for (int i = 15; i >= 0; i--) begin
            cyc();
            chk("shift_bit", o1, {a[i], b[i], 1'b1, (i == 15), (i == 0), 1'b0});
        end
    endtask

    initial begin
        rst = 1'b1; abort = 1'b0; lv = 1'b0; wa = '0; wb = '0;
        lv2 = 1'b0; wa2 = '0; wb2 = '0;
        cyc(); cyc();
        chk("reset_outs", o1, 6'b0);
        rst = 1'b0;
        #1;
        chk("reset_ready", ready, 1'b1);
        chk("reset_frames", frames, 8'd0);
        chk("reset_frames2", frames2, 2'd0);

        // single load
        wa = 16'h3BC7; wb = 16'h3BF8; lv = 1'b1;
        #1;
        chk("idle_ready", ready, 1'b1);
        cyc();
        chk("sync_outs", o1, 6'b000001);
        chk("sync_ready", ready, 1'b0);
        lv = 1'b0; wa = 16'hFFFF; wb = 16'hFFFF;
        shift_check(16'h3BC7, 16'h3BF8);
        cyc();
        chk("single_idle", o1, 6'b0);
        chk("single_frames", frames, 8'd1);
        chk("single_ready", ready, 1'b1);

        // back-to-back
        rst = 1'b1; cyc(); rst = 1'b0;
        busy = 0;
        wa = 16'hFFFF; wb = 16'h0000; lv = 1'b1;
        cyc();
        chk("b2b_sync1", o1, 6'b000001);
        wa = 16'h8001; wb = 16'h7FFE;
        shift_check(16'hFFFF, 16'h0000);
        chk("b2b_lsb_ready", ready, 1'b1);
        cyc();
        chk("b2b_sync2", o1, 6'b000001);
        lv = 1'b0;
        shift_check(16'h8001, 16'h7FFE);
        cyc();
        chk("b2b_idle", o1, 6'b0);
        chk("b2b_busy", busy, 34);
        chk("b2b_frames", frames, 8'd2);

        // abort mid-frame at cnt=7
        wa = 16'h12B4; wb = 16'h5698; lv = 1'b1;
        cyc();
        lv = 1'b0;
        repeat (9) cyc();
        chk("abort_bit7", o1, 6'b111000);
        abort = 1'b1;
        #1;
        chk("abort_ready_low", ready, 1'b0);
        cyc();
        abort = 1'b0;
        #1;
        chk("abort_idle", o1, 6'b0);
        chk("abort_frames", frames, 8'd2);
        chk("abort_ready", ready, 1'b1);
        cyc();
        chk("abort_stays_idle", o1, 6'b0);

        // abort coinciding with last bit and a load
        wa = 16'hFFFF; wb = 16'hFFFF; lv = 1'b1;
        cyc();
        lv = 1'b0;
        repeat (16) cyc();
        chk("abortlsb_bit0", o1, 6'b111010);
        abort = 1'b1; lv = 1'b1; wa = 16'hAAAA; wb = 16'h5555;
        #1;
        chk("abortlsb_ready", ready, 1'b0);
        cyc();
        abort = 1'b0; lv = 1'b0;
        chk("abortlsb_no_sync", o1, 6'b0);
        chk("abortlsb_frames", frames, 8'd2);
        cyc();
        chk("abortlsb_idle", o1, 6'b0);

        // reset mid-frame at cnt=10
        wa = 16'hC3A5; wb = 16'h0F0F; lv = 1'b1;
        cyc();
        lv = 1'b0;
        repeat (6) cyc();
        chk("rstmid_bv", bv, 1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("rstmid_outs", o1, 6'b0);
        chk("rstmid_frames", frames, 8'd0);
        chk("rstmid_ready", ready, 1'b1);
        wa = 16'hA5C3; wb = 16'h1E2D; lv = 1'b1;
        cyc();
        chk("rstmid_sync", o1, 6'b000001);
        lv = 1'b0;
        shift_check(16'hA5C3, 16'h1E2D);
        cyc();
        chk("rstmid_frames_after", frames, 8'd1);

        // WIDTH=2 cadence and 2-bit counter wrap
        wa2 = 2'b10; wb2 = 2'b01; lv2 = 1'b1;
        cyc();
        chk("w2_sync", o2, 6'b000001);
        for (int f = 0; f < 5; f++) begin
            cyc();
            chk("w2_msb", o2, 6'b101100);
            cyc();
            chk("w2_lsb", o2, 6'b011010);
            chk("w2_ready", ready2, 1'b1);
            if (f == 4) lv2 = 1'b0;
            cyc();
            chk("w2_frames", frames2, wrap_exp[f]);
            chk("w2_frame_rst", frst2, (f != 4));
        end
        cyc();
        chk("w2_idle", o2, 6'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
